prescaled_updown_counter: RTL and testbench

PRESCALED_UPDOWN_COUNTER -- requirements
Module: prescaled_updown_counter

---
 rtl/prescaled_updown_counter.sv | 105 ++++++++++
 tb/tb_prescaled_updown_counter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/prescaled_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : prescaled_updown_counter
// Brief    : Up/down counter stepping once every div_sel+1 enabled clocks,
//            with wrap/saturate end-of-range handling, tc pulse and sticky ovf.
// Revision : 1.0
// ============================================================================
module prescaled_updown_counter #(
    parameter int WIDTH     = 4,
    parameter int DIV_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [DIV_WIDTH-1:0] div_sel,
    input  logic                 sat_mode,
    input  logic                 clr,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    output logic [DIV_WIDTH-1:0] clk_d,
    output logic [WIDTH-1:0]     counter,
    output logic                 tick,
    output logic                 tc,
    output logic                 ovf
);

    logic [DIV_WIDTH-1:0] r_clk_d;
    logic [WIDTH-1:0]     r_counter;
    logic                 r_tc;
    logic                 r_ovf;

    logic                 w_tick;
    logic                 w_at_max;
    logic                 w_at_min;
    logic                 w_at_end;
    logic [WIDTH-1:0]     w_step_val;

    // rst is folded in so the strobe stays low throughout an asynchronous reset
    assign w_tick = en && (r_clk_d == div_sel) && !clr && !load && !rst;

    assign w_at_max = &r_counter;
    assign w_at_min = (r_counter == '0);
    assign w_at_end = mode ? w_at_max : w_at_min;

    always_comb begin
        w_step_val = r_counter;
        if (mode) begin
            if (w_at_max) begin
                w_step_val = sat_mode ? r_counter : '0;
            end else begin
                w_step_val = r_counter + WIDTH'(1);
            end
        end else begin
            if (w_at_min) begin
                w_step_val = sat_mode ? r_counter : '1;
            end else begin
                w_step_val = r_counter - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_counter <= '0;
            r_clk_d   <= '0;
            r_tc      <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (clr) begin
            r_counter <= '0;
            r_clk_d   <= '0;
            r_tc      <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (load) begin
            r_counter <= load_val;
            r_clk_d   <= '0;
            r_tc      <= 1'b0;
        end else if (w_tick) begin
            r_counter <= w_step_val;
            r_clk_d   <= '0;
            r_tc      <= w_at_end;
            if (w_at_end) begin
                r_ovf <= 1'b1;
            end
        end else if (en) begin
            r_tc <= 1'b0;
            // A lowered div_sel can leave clk_d above the new ratio: restart the period
            if (r_clk_d < div_sel) begin
                r_clk_d <= r_clk_d + DIV_WIDTH'(1);
            end else begin
                r_clk_d <= '0;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign clk_d   = r_clk_d;
    assign counter = r_counter;
    assign tick    = w_tick;
    assign tc      = r_tc;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_prescaled_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prescaled_updown_counter
// Brief    : Directed table-driven bench for prescaled_updown_counter.
// Revision : 1.0
// ============================================================================
module tb_prescaled_updown_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [2:0] div_sel;
    logic       sat_mode;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic [2:0] clk_d;
    logic [3:0] counter;
    logic       tick;
    logic       tc;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       r;
        logic       e;
        logic       m;
        logic [2:0] d;
        logic       s;
        logic       c;
        logic       l;
        logic [3:0] lv;
        logic       x_tick;
        logic [3:0] x_cnt;
        logic [2:0] x_clkd;
        logic       x_tc;
        logic       x_ovf;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    prescaled_updown_counter #(.WIDTH(4), .DIV_WIDTH(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .div_sel  (div_sel),
        .sat_mode (sat_mode),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .clk_d    (clk_d),
        .counter  (counter),
        .tick     (tick),
        .tc       (tc),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic m, input logic [2:0] d,
                       input logic s, input logic c, input logic l, input logic [3:0] lv,
                       input logic tk, input logic [3:0] xc, input logic [2:0] xd,
                       input logic xt, input logic xo);
        vecs[nv] = '{r, e, m, d, s, c, l, lv, tk, xc, xd, xt, xo};
        nv++;
    endtask

    task automatic drive(input vec_t v);
        rst      = v.r;
        en       = v.e;
        mode     = v.m;
        div_sel  = v.d;
        sat_mode = v.s;
        clr      = v.c;
        load     = v.l;
        load_val = v.lv;
    endtask

    initial begin
        //  r  e  m  d  s  c  l  lv | tick cnt clkd tc ovf
        // wrap up from 14
        add(0, 1, 1, 0, 0, 0, 1, 14,  0, 14, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0,   1, 15, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0,   1, 0,  0, 1, 1);
        add(0, 1, 1, 0, 0, 0, 0, 0,   1, 1,  0, 0, 1);
        add(0, 1, 1, 0, 0, 1, 0, 0,   0, 0,  0, 0, 0);
        // prescale by 4, with an en=0 freeze
        add(0, 1, 1, 3, 0, 0, 0, 0,   0, 0,  1, 0, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0,   0, 0,  2, 0, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0,   0, 0,  3, 0, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0,   1, 1,  0, 0, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0,   0, 1,  1, 0, 0);
        add(0, 0, 1, 3, 0, 0, 0, 0,   0, 1,  1, 0, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0,   0, 1,  2, 0, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0,   0, 1,  3, 0, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0,   1, 2,  0, 0, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0,   0, 2,  1, 0, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0,   0, 2,  2, 0, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0,   0, 2,  3, 0, 0);
        // load on a tick cycle, clr+load together, load with en=0
        add(0, 1, 1, 3, 0, 0, 1, 5,   0, 5,  0, 0, 0);
        add(0, 1, 1, 3, 0, 1, 1, 9,   0, 0,  0, 0, 0);
        add(0, 0, 1, 3, 0, 0, 1, 9,   0, 9,  0, 0, 0);
        // saturate down from 2
        add(0, 1, 0, 0, 1, 0, 1, 2,   0, 2,  0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0,   1, 1,  0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0,   1, 0,  0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0,   1, 0,  0, 1, 1);
        add(0, 1, 0, 0, 1, 0, 0, 0,   1, 0,  0, 1, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0,   0, 0,  0, 0, 1);
        add(0, 1, 0, 0, 1, 0, 1, 7,   0, 7,  0, 0, 1);
        // wrap down, then saturate up at all-ones
        add(0, 1, 0, 0, 0, 0, 1, 0,   0, 0,  0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0,   1, 15, 0, 1, 1);
        add(0, 1, 1, 0, 1, 0, 0, 0,   1, 15, 0, 1, 1);
        add(0, 1, 1, 0, 1, 0, 0, 0,   1, 15, 0, 1, 1);
        add(0, 1, 1, 0, 1, 1, 0, 0,   0, 0,  0, 0, 0);
        // mode change mid-period takes effect at the tick
        add(0, 1, 1, 1, 0, 0, 0, 0,   0, 0,  1, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0, 0,   1, 15, 0, 1, 1);
        add(0, 1, 1, 1, 0, 1, 0, 0,   0, 0,  0, 0, 0);
        // ratio change 7 -> 1 with clk_d at 5
        add(0, 1, 1, 7, 0, 0, 0, 0,   0, 0,  1, 0, 0);
        add(0, 1, 1, 7, 0, 0, 0, 0,   0, 0,  2, 0, 0);
        add(0, 1, 1, 7, 0, 0, 0, 0,   0, 0,  3, 0, 0);
        add(0, 1, 1, 7, 0, 0, 0, 0,   0, 0,  4, 0, 0);
        add(0, 1, 1, 7, 0, 0, 0, 0,   0, 0,  5, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0, 0,   0, 0,  0, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0, 0,   0, 0,  1, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0, 0,   1, 1,  0, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0, 0,   0, 1,  1, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0, 0,   1, 2,  0, 0, 0);
        // reset mid-period discards the partial count
        add(0, 1, 1, 3, 0, 0, 0, 0,   0, 2,  1, 0, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0,   0, 2,  2, 0, 0);
        add(1, 1, 1, 3, 0, 0, 0, 0,   0, 0,  0, 0, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0,   0, 0,  1, 0, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0,   0, 0,  2, 0, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0,   0, 0,  3, 0, 0);
        add(0, 1, 1, 3, 0, 0, 0, 0,   1, 1,  0, 0, 0);

        // reset state, with tick held low despite en=1 and div_sel=0
        rst = 1'b1; en = 1'b1; mode = 1'b1; div_sel = 3'd0; sat_mode = 1'b0;
        clr = 1'b0; load = 1'b0; load_val = 4'd0;
        #2;
        check("rst_counter", -1, 32'(counter), 32'd0);
        check("rst_clk_d",   -1, 32'(clk_d),   32'd0);
        check("rst_tc",      -1, 32'(tc),      32'd0);
        check("rst_ovf",     -1, 32'(ovf),     32'd0);
        check("rst_tick",    -1, 32'(tick),    32'd0);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;

        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check("tick", i, 32'(tick), 32'(vecs[i].x_tick));
            @(posedge clk);
            #1;
            check("counter", i, 32'(counter), 32'(vecs[i].x_cnt));
            check("clk_d",   i, 32'(clk_d),   32'(vecs[i].x_clkd));
            check("tc",      i, 32'(tc),      32'(vecs[i].x_tc));
            check("ovf",     i, 32'(ovf),     32'(vecs[i].x_ovf));
        end

        // asynchronous reset between edges with counter=9 and ovf set
        @(negedge clk);
        rst = 1'b0; en = 1'b1; mode = 1'b1; div_sel = 3'd0; sat_mode = 1'b0;
        clr = 1'b0; load = 1'b1; load_val = 4'd15;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        load = 1'b1; load_val = 4'd9;
        @(posedge clk);
        #1;
        check("pre_async_counter", 100, 32'(counter), 32'd9);
        check("pre_async_ovf",     100, 32'(ovf),     32'd1);
        @(negedge clk);
        load = 1'b0; en = 1'b1; div_sel = 3'd3;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_counter", 101, 32'(counter), 32'd0);
        check("async_clk_d",   101, 32'(clk_d),   32'd0);
        check("async_ovf",     101, 32'(ovf),     32'd0);
        check("async_tc",      101, 32'(tc),      32'd0);
        check("async_tick",    101, 32'(tick),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
